commit_trace_checker: RTL and testbench
=======================================

Name: commit_trace_checker

Overview:
- Synthesizable lockstep checker that compares the core's per-retire commit stream (PC plus register write-back) against a golden reference commit stream, in hardware.
- Replaces the fixed-length per-cycle golden compare used in simulation-only benches.
- Parametrised in XLEN, buffer depth, commit count width and timeout.
- Sits beside the core top, fed by its write-back stage on one side and a golden-trace source (ROM/DMA/bench driver) on the other.

Parameters:
XLEN, 32, width of PC and register data
DEPTH, 8, DUT commit buffer entries (power of 2, >=2)
CNT_W, 16, width of commit/error counters and expected-commit input
TIMEOUT_CYC, 1000, consecutive cycles without a compare before timeout
STOP_AFTER_ERR, 0, stop checking after this many mismatches (0 = never stop)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear results, begin a run (accepted in IDLE, DONE, TIMEOUT)
num_commits  in  CNT_W  commits expected in the run; sampled on start
dut_valid  in  1  core retired an instruction this cycle (no backpressure)
dut_pc  in  XLEN  retired PC
dut_we  in  1  retired instruction writes rd
dut_rd  in  5  destination register
dut_wdata  in  XLEN  write-back data
gold_valid  in  1  golden record available
gold_ready  out  1  golden record consumed this cycle
gold_pc, gold_we, gold_rd, gold_wdata  in  XLEN/1/5/XLEN  golden record fields
busy  out  1  state is RUN
done  out  1  run finished (DONE or TIMEOUT), sticky until start
pass  out  1  done and err_count==0 and no overflow and no timeout
err_count  out  CNT_W  mismatching commits, saturating
commit_count  out  CNT_W  commits compared
first_err_valid  out  1  a mismatch has been captured
first_err_idx  out  CNT_W  commit index of the first mismatch
first_err_pc  out  XLEN  DUT PC of the first mismatch
first_err_mask  out  4  bit0 PC, bit1 WE, bit2 RD, bit3 WDATA
overflow  out  1  sticky: DUT commit arrived while buffer full
timeout  out  1  sticky: timeout ended the run

Behaviour:
- Reset: state IDLE; all outputs 0; buffer empty; counters 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE when commit_count reaches the sampled num_commits, or when err_count reaches STOP_AFTER_ERR (when nonzero).
  - RUN -> TIMEOUT when the idle counter reaches TIMEOUT_CYC.
  - DONE/TIMEOUT -> RUN on start.
  - start is ignored while in RUN.
  - start with num_commits==0 goes straight to DONE with pass=1.
- start clears: counters, first_err_*, overflow, timeout, done, buffer.
- DUT side: in RUN, dut_valid pushes {pc,we,rd,wdata} into the FIFO.
  - Push when full: record is dropped and overflow is set.
  - Pushes outside RUN are ignored.
- Compare fires in RUN when FIFO non-empty and gold_valid.
  - Same cycle: gold_ready=1, FIFO pops, commit_count increments.
  - gold_ready is 0 otherwise.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full (pop frees the slot first).
- Mismatch mask for each compare:
  - PC: pc differs.
  - WE: we differs.
  - RD: both we=1 and rd differs.
  - WDATA: both we=1, gold_rd!=0, and wdata differs.
  - Writes to x0 are never data-checked.
- Any mask bit set: err_count increments, saturating at all-ones.
  - First such compare latches first_err_idx (= commit_count before increment), first_err_pc and mask; later mismatches do not overwrite them.
- Idle counter: resets on every compare; increments in RUN otherwise; cleared on start.
- Latency: result counters and flags update on the clock edge after the compare cycle. Final-commit compare -> done=1 on the next edge.
- reset_n assertion mid-run aborts immediately to reset values.

Decomposition:
- Package commit_chk_pkg holds:
  - parametrised commit record struct {pc, we, rd, wdata};
  - state enum {IDLE, RUN, DONE, TIMEOUT};
  - mask bit index constants MSK_PC/MSK_WE/MSK_RD/MSK_WDATA.
- Sub-module commit_fifo (DEPTH, record width) provides the synchronous FIFO with full/empty, same-cycle push/pop, and a sync clear driven by start.

Test Plan:
- num_commits=4; 4 identical commits (pc 0,4,8,C; x1..x4=1..4), golden valid throughout -> done 1 cycle after 4th compare, pass=1, commit_count=4, err_count=0.
- Commit #2 DUT wdata=0x5 vs gold 0x6, rd=3 -> err_count=1, first_err_idx=2, mask=4'b1000, pass=0; a later PC mismatch leaves first_err_* unchanged.
- DUT writes x0 with 0x7, golden writes x0 with 0 -> no error. DUT we=0 vs gold we=1 -> mask=4'b0010.
- gold_valid held low while DUT retires DEPTH+1 commits -> overflow=1, DEPTH entries buffered; raising gold_valid drains at 1 compare/cycle.
- TIMEOUT_CYC=20, no golden records after start -> timeout=1, done=1, pass=0 on cycle 20. A new start clears all results.
- reset_n low for 1 cycle mid-run with err_count=3 -> all outputs 0, IDLE. STOP_AFTER_ERR=2 -> DONE after 2nd mismatch.

Source files
------------

// File: rtl/commit_chk_pkg.sv
// Shared types and constants for the lockstep commit trace checker.
package commit_chk_pkg;

    localparam int unsigned RD_W      = 5;
    localparam int unsigned MSK_W     = 4;
    localparam int unsigned MSK_PC    = 0;
    localparam int unsigned MSK_WE    = 1;
    localparam int unsigned MSK_RD    = 2;
    localparam int unsigned MSK_WDATA = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        TIMEOUT
    } state_e;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO for retired DUT commits; a pop frees its slot for a same-cycle push.
module commit_fifo
    import commit_chk_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares the core's retire stream against a golden commit stream and reports run results.
module commit_trace_checker
    import commit_chk_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYC    = 1000,
    parameter int unsigned STOP_AFTER_ERR = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_commits,
    input  logic             dut_valid,
    input  logic [XLEN-1:0]  dut_pc,
    input  logic             dut_we,
    input  logic [RD_W-1:0]  dut_rd,
    input  logic [XLEN-1:0]  dut_wdata,
    input  logic             gold_valid,
    output logic             gold_ready,
    input  logic [XLEN-1:0]  gold_pc,
    input  logic             gold_we,
    input  logic [RD_W-1:0]  gold_rd,
    input  logic [XLEN-1:0]  gold_wdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] commit_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [XLEN-1:0]  first_err_pc,
    output logic [MSK_W-1:0] first_err_mask,
    output logic             overflow,
    output logic             timeout
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            we;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] wdata;
    } commit_rec_t;

    localparam int unsigned REC_W  = $bits(commit_rec_t);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_e           state;
    logic [CNT_W-1:0] num_q;
    logic [IDLE_W-1:0] idle_cnt;
    commit_rec_t      dut_rec;
    commit_rec_t      gold_rec;
    commit_rec_t      fifo_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             running;
    logic             cmp;
    logic             push;
    logic             drop;
    logic             clr;
    logic [MSK_W-1:0] mask;
    logic             err_hit;
    logic             stop_hit;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] err_n;
    logic             ovf_n;
    logic [IDLE_W-1:0] idle_n;

    assign dut_rec  = {dut_pc, dut_we, dut_rd, dut_wdata};
    assign gold_rec = {gold_pc, gold_we, gold_rd, gold_wdata};

    assign running    = (state == RUN);
    assign cmp        = running & ~fifo_empty & gold_valid;
    assign gold_ready = cmp;
    assign push       = running & dut_valid & (~fifo_full | cmp);
    assign drop       = running & dut_valid & fifo_full & ~cmp;
    assign clr        = start & ~running;

    commit_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .push    (push),
        .pop     (cmp),
        .wdata   (dut_rec),
        .rdata   (fifo_rec),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Register and data fields only matter when both sides write; x0 data is never checked.
    always_comb begin
        mask            = '0;
        mask[MSK_PC]    = (fifo_rec.pc != gold_rec.pc);
        mask[MSK_WE]    = (fifo_rec.we != gold_rec.we);
        mask[MSK_RD]    = fifo_rec.we & gold_rec.we & (fifo_rec.rd != gold_rec.rd);
        mask[MSK_WDATA] = fifo_rec.we & gold_rec.we & (gold_rec.rd != '0)
                          & (fifo_rec.wdata != gold_rec.wdata);
    end

    always_comb begin
        err_hit  = cmp & (|mask);
        cnt_n    = commit_count + CNT_W'(cmp);
        err_n    = (err_hit && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
        ovf_n    = overflow | drop;
        idle_n   = cmp ? '0 : idle_cnt + 1'b1;
        stop_hit = (STOP_AFTER_ERR != 0) && (err_n >= CNT_W'(STOP_AFTER_ERR));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            num_q           <= '0;
            idle_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            commit_count    <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_pc    <= '0;
            first_err_mask  <= '0;
            overflow        <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    commit_count <= cnt_n;
                    err_count    <= err_n;
                    overflow     <= ovf_n;
                    idle_cnt     <= idle_n;
                    if (err_hit && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= commit_count;
                        first_err_pc    <= fifo_rec.pc;
                        first_err_mask  <= mask;
                    end
                    if (cmp && ((cnt_n == num_q) || stop_hit)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_n == '0) && !ovf_n;
                    end else if (idle_n == IDLE_W'(TIMEOUT_CYC)) begin
                        state   <= TIMEOUT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: begin
                    // IDLE, DONE and TIMEOUT all accept a new run.
                    if (start) begin
                        num_q           <= num_commits;
                        idle_cnt        <= '0;
                        err_count       <= '0;
                        commit_count    <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        first_err_pc    <= '0;
                        first_err_mask  <= '0;
                        overflow        <= 1'b0;
                        timeout         <= 1'b0;
                        if (num_commits == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker: directed tables, corner sequences and a random run vs a queue model.
module tb_commit_trace_checker;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 20;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rec_t;

    typedef struct {
        rec_t       d;
        rec_t       g;
        logic [3:0] mask;
    } mvec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_commits = '0;
    logic        dut_valid = 1'b0, dut_we = 1'b0, gold_valid = 1'b0, gold_we = 1'b0;
    logic [31:0] dut_pc = '0, dut_wdata = '0, gold_pc = '0, gold_wdata = '0;
    logic [4:0]  dut_rd = '0, gold_rd = '0;

    logic        gold_ready, busy, done, pass, first_err_valid, overflow, timeout;
    logic [15:0] err_count, commit_count, first_err_idx;
    logic [31:0] first_err_pc;
    logic [3:0]  first_err_mask;

    logic        s_gold_ready, s_busy, s_done, s_pass, s_fev, s_ovf, s_to;
    logic [15:0] s_err, s_cnt, s_fidx;
    logic [31:0] s_fpc;
    logic [3:0]  s_fmask;

    always #5 clk = ~clk;

    commit_trace_checker #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT_CYC(TMO), .STOP_AFTER_ERR(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_commits(num_commits),
        .dut_valid(dut_valid), .dut_pc(dut_pc), .dut_we(dut_we), .dut_rd(dut_rd), .dut_wdata(dut_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc), .gold_we(gold_we),
        .gold_rd(gold_rd), .gold_wdata(gold_wdata), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .commit_count(commit_count), .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx), .first_err_pc(first_err_pc), .first_err_mask(first_err_mask),
        .overflow(overflow), .timeout(timeout));

    commit_trace_checker #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT_CYC(TMO), .STOP_AFTER_ERR(2)) u_stop (
        .clk(clk), .reset_n(reset_n), .start(start), .num_commits(num_commits),
        .dut_valid(dut_valid), .dut_pc(dut_pc), .dut_we(dut_we), .dut_rd(dut_rd), .dut_wdata(dut_wdata),
        .gold_valid(gold_valid), .gold_ready(s_gold_ready), .gold_pc(gold_pc), .gold_we(gold_we),
        .gold_rd(gold_rd), .gold_wdata(gold_wdata), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .commit_count(s_cnt), .first_err_valid(s_fev),
        .first_err_idx(s_fidx), .first_err_pc(s_fpc), .first_err_mask(s_fmask),
        .overflow(s_ovf), .timeout(s_to));

    int unsigned n_chk = 0, n_pass = 0;

    // Behavioural reference: a queue of pending DUT commits plus run bookkeeping.
    bit          m_run, m_done, m_pass, m_fev, m_ovf, m_to;
    int unsigned m_err, m_idle;
    logic [15:0] m_cnt, m_fidx, m_n;
    logic [31:0] m_fpc;
    logic [3:0]  m_fmask;
    rec_t        m_q[$];

    rec_t        dut_src[$], gold_src[$];
    int unsigned dut_pct = 100, gold_pct = 100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd, input logic [31:0] wd);
        rec_t r;
        r.pc = pc; r.we = we; r.rd = rd; r.wdata = wd;
        return r;
    endfunction

    function automatic logic [3:0] ref_mask(input rec_t d, input rec_t g);
        logic [3:0] m;
        m[0] = d.pc != g.pc;
        m[1] = d.we != g.we;
        m[2] = d.we && g.we && (d.rd != g.rd);
        m[3] = d.we && g.we && (g.rd != 0) && (d.wdata != g.wdata);
        return m;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_fev = 0; m_ovf = 0; m_to = 0;
        m_err = 0; m_idle = 0; m_cnt = 0; m_fidx = 0; m_n = 0; m_fpc = 0; m_fmask = 0;
        m_q.delete();
    endtask

    task automatic model_step(input rec_t d, input rec_t g);
        bit c;
        rec_t r;
        logic [3:0] mk_;
        c = m_run && (m_q.size() != 0) && gold_valid;
        if (!m_run) begin
            if (start) begin
                model_reset();
                m_n = num_commits;
                if (m_n == 0) begin m_done = 1; m_pass = 1; end
                else m_run = 1;
            end
        end else begin
            if (c) begin
                r = m_q.pop_front();
                mk_ = ref_mask(r, g);
                if (mk_ != 0) begin
                    if (!m_fev) begin m_fev = 1; m_fidx = m_cnt; m_fpc = r.pc; m_fmask = mk_; end
                    if (m_err < 65535) m_err++;
                end
                m_cnt = m_cnt + 16'd1;
            end
            if (dut_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1;
            end
            m_idle = c ? 0 : m_idle + 1;
            if (c && m_cnt == m_n) begin
                m_run = 0; m_done = 1; m_pass = (m_err == 0) && !m_ovf;
            end else if (m_idle == TMO) begin
                m_run = 0; m_done = 1; m_to = 1; m_pass = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("err_count", err_count, m_err);
        chk("commit_count", commit_count, m_cnt);
        chk("first_err_valid", first_err_valid, m_fev);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_pc", first_err_pc, m_fpc);
        chk("first_err_mask", first_err_mask, m_fmask);
        chk("overflow", overflow, m_ovf);
        chk("timeout", timeout, m_to);
    endtask

    // One clock: present source records, check the handshake, step the model, check registered outputs.
    task automatic tick();
        rec_t d, g;
        bit   rdy;
        d = '0; g = '0;
        dut_valid  = (dut_src.size() != 0) && ($urandom_range(99) < dut_pct);
        if (dut_valid) d = dut_src[0];
        gold_valid = (gold_src.size() != 0) && ($urandom_range(99) < gold_pct);
        if (gold_valid) g = gold_src[0];
        {dut_pc, dut_we, dut_rd, dut_wdata}     = d;
        {gold_pc, gold_we, gold_rd, gold_wdata} = g;
        #1;
        rdy = m_run && (m_q.size() != 0) && gold_valid;
        chk("gold_ready", gold_ready, rdy);
        model_step(d, g);
        if (dut_valid) void'(dut_src.pop_front());
        if (rdy) void'(gold_src.pop_front());
        @(posedge clk); #1;
        check_model();
        @(negedge clk);
        start = 0;
    endtask

    task automatic begin_run(input logic [15:0] n);
        dut_src.delete(); gold_src.delete();
        start = 1; num_commits = n;
        tick();
    endtask

    task automatic run_until_done(input int bound, input string nm);
        int k = 0;
        while (!m_done && k < bound) begin tick(); k++; end
        chk(nm, done, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 0; start = 0; dut_valid = 0; gold_valid = 0;
        dut_src.delete(); gold_src.delete();
        #1;
        model_reset();
        check_model();
        @(posedge clk); @(negedge clk);
        reset_n = 1;
    endtask

    mvec_t mtab[6];

    initial begin
        rec_t r, g;
        mtab[0] = '{mk(32'h100, 1, 0, 7),  mk(32'h100, 1, 0, 0),  4'b0000};
        mtab[1] = '{mk(32'h104, 0, 5, 9),  mk(32'h104, 1, 5, 9),  4'b0010};
        mtab[2] = '{mk(32'h108, 1, 6, 1),  mk(32'h108, 1, 7, 1),  4'b0100};
        mtab[3] = '{mk(32'h10C, 0, 3, 1),  mk(32'h10C, 0, 4, 2),  4'b0000};
        mtab[4] = '{mk(32'h110, 1, 7, 1),  mk(32'h114, 1, 7, 2),  4'b1001};
        mtab[5] = '{mk(32'h118, 1, 2, 5),  mk(32'h118, 1, 0, 6),  4'b0100};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset_n = 1;

        // Four matching commits, golden always valid.
        begin_run(16'd4);
        for (int i = 0; i < 4; i++) begin
            r = mk(32'(4 * i), 1, 5'(i + 1), 32'(i + 1));
            dut_src.push_back(r); gold_src.push_back(r);
        end
        run_until_done(20, "basic_done");
        chk("basic_pass", pass, 1'b1);
        chk("basic_cnt", commit_count, 16'd4);
        chk("basic_err", err_count, 16'd0);

        // Data mismatch on commit 2 followed by a PC mismatch on commit 3.
        begin_run(16'd4);
        for (int i = 0; i < 4; i++) begin
            r = mk(32'(4 * i), 1, 5'(i + 1), 32'(i + 1));
            g = r;
            if (i == 2) begin r.wdata = 32'h5; g.wdata = 32'h6; end
            if (i == 3) g.pc = 32'h10;
            dut_src.push_back(r); gold_src.push_back(g);
        end
        run_until_done(20, "err_done");
        chk("err_count2", err_count, 16'd2);
        chk("err_idx", first_err_idx, 16'd2);
        chk("err_pc", first_err_pc, 32'h8);
        chk("err_mask", first_err_mask, 4'b1000);
        chk("err_pass", pass, 1'b0);

        // Mask-rule table, one single-commit run per row.
        for (int i = 0; i < 6; i++) begin
            begin_run(16'd1);
            dut_src.push_back(mtab[i].d); gold_src.push_back(mtab[i].g);
            run_until_done(10, "mask_done");
            chk("mask_bits", first_err_mask, mtab[i].mask);
            chk("mask_err", err_count, 16'(mtab[i].mask != 0));
            chk("mask_pass", pass, mtab[i].mask == 0);
        end

        // Overflow with golden stalled, then drain at one compare per cycle.
        begin_run(16'(DEPTH + 1));
        for (int i = 0; i <= DEPTH; i++) begin
            r = mk(32'(16 * i), 1, 5'(i + 1), 32'(i));
            dut_src.push_back(r); gold_src.push_back(r);
        end
        gold_pct = 0;
        for (int i = 0; i <= DEPTH; i++) tick();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_cnt0", commit_count, 16'd0);
        gold_pct = 100;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk("drain_cnt", commit_count, 16'(k));
        end
        run_until_done(40, "ovf_done");
        chk("ovf_to", timeout, 1'b1);
        chk("ovf_pass", pass, 1'b0);

        // Timeout lands exactly TMO cycles after start with nothing to compare.
        begin_run(16'd5);
        for (int i = 1; i < TMO; i++) tick();
        chk("to_early", timeout, 1'b0);
        tick();
        chk("to_set", timeout, 1'b1);
        chk("to_done", done, 1'b1);
        chk("to_pass", pass, 1'b0);
        begin_run(16'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_pass", pass, 1'b1);
        chk("zero_to", timeout, 1'b0);
        chk("zero_busy", busy, 1'b0);

        // Reset mid-run after three mismatches.
        begin_run(16'd10);
        for (int i = 0; i < 3; i++) begin
            r = mk(32'(4 * i), 1, 5'd1, 32'd1);
            g = r; g.pc = r.pc + 32'd2;
            dut_src.push_back(r); gold_src.push_back(g);
        end
        for (int k = 0; k < 10 && m_err < 3; k++) tick();
        chk("rst_err3", err_count, 16'd3);
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_count, 16'd0);

        // Second mismatch stops the STOP_AFTER_ERR=2 instance early.
        begin_run(16'd5);
        for (int i = 0; i < 5; i++) begin
            r = mk(32'h40 + 32'(4 * i), 1, 5'(i + 1), 32'h10 + 32'(i));
            g = r;
            if (i == 1 || i == 2) g.wdata = r.wdata ^ 32'h1;
            dut_src.push_back(r); gold_src.push_back(g);
        end
        run_until_done(20, "stop_main_done");
        chk("stop_done", s_done, 1'b1);
        chk("stop_busy", s_busy, 1'b0);
        chk("stop_err", s_err, 16'd2);
        chk("stop_cnt", s_cnt, 16'd3);
        chk("stop_pass", s_pass, 1'b0);
        chk("stop_fev", s_fev, 1'b1);
        chk("stop_fidx", s_fidx, 16'd1);
        chk("stop_fpc", s_fpc, 32'h44);
        chk("stop_fmask", s_fmask, 4'b1000);
        chk("stop_flags", {s_ovf, s_to, s_gold_ready}, 3'b000);

        // Random runs with throttled sources, corrupted golden fields and stray start pulses.
        dut_pct = 70; gold_pct = 70;
        for (int run = 0; run < 8; run++) begin
            int n;
            int k;
            n = $urandom_range(30, 1);
            begin_run(16'(n));
            for (int i = 0; i < n; i++) begin
                r = mk($urandom, 1'($urandom), 5'($urandom), $urandom);
                g = r;
                case ($urandom_range(7))
                    0: g.pc    = g.pc ^ (32'h1 << $urandom_range(31));
                    1: g.we    = ~g.we;
                    2: g.rd    = 5'($urandom);
                    3: g.wdata = $urandom;
                    default: ;
                endcase
                dut_src.push_back(r); gold_src.push_back(g);
            end
            k = 0;
            while (!m_done && k < 600) begin
                start = ($urandom_range(49) == 0);
                num_commits = 16'($urandom);
                tick();
                k++;
            end
            chk("rand_done", done, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
